// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: FSM state encoding, EX/MEM register
// contents, and a helper that derives the stage state from the register.
package mem_stage_pkg;

  localparam int N = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MEM  = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic         valid;
    logic         mem_read;
    logic         mem_write;
    logic         branch;
    logic         zero;
    logic [N-1:0] alu_result;
    logic [N-1:0] write_data;
    logic [N-1:0] pc_branch;
  } exmem_t;

  // The stage state is not stored separately: it is fully implied by what
  // the EX/MEM register currently holds.
  function automatic mem_state_t state_of(input exmem_t r);
    mem_state_t s;
    if (!r.valid) begin
      s = IDLE;
    end else if (r.mem_read || r.mem_write) begin
      s = MEM;
    end else begin
      s = EXEC;
    end
    return s;
  endfunction

endpackage

// File: rtl/mem_access_stage_exmem_reg.sv
// Enabled pipeline register with synchronous clear. The payload type is a
// parameter so the same block can serve the MEM/WB register later.
module exmem_reg
  import mem_stage_pkg::*;
#(
  parameter type T = exmem_t
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  T     d,
  output T     q
);

  // Capture when enabled, hold otherwise, clear on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: latches execute results, runs a req/ack data-memory
// handshake for loads/stores, stalls execute while waiting, and hands a
// registered result plus branch decision to writeback.
module mem_access_stage
  import mem_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         MemRead_E,
  input  logic         MemWrite_E,
  input  logic         Branch_E,
  input  logic         zero_E,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic [N-1:0] PCBranch_E,
  output logic         stall_M,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic [N-1:0] dm_rdata,
  input  logic         dm_ack,
  output logic         valid_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] readData_M,
  output logic [N-1:0] PCBranch_M,
  output logic         PCSrc_M
);

  exmem_t     ex_s;
  exmem_t     exmem_r;
  mem_state_t state_s;
  logic       stall_s;
  logic       complete_s;

  // Pack execute outputs; a bubble loads an all-empty register.
  always_comb begin
    ex_s = '0;
    if (valid_E) begin
      ex_s.valid      = 1'b1;
      ex_s.mem_read   = MemRead_E;
      ex_s.mem_write  = MemWrite_E;
      ex_s.branch     = Branch_E;
      ex_s.zero       = zero_E;
      ex_s.alu_result = aluResult_E;
      ex_s.write_data = writeData_E;
      ex_s.pc_branch  = PCBranch_E;
    end else begin
      ex_s = '0;
    end
  end

  exmem_reg #(.T(exmem_t)) u_exmem (
    .clk   (clk),
    .reset (reset),
    .en    (~stall_s),
    .d     (ex_s),
    .q     (exmem_r)
  );

  assign state_s = state_of(exmem_r);

  // Decide whether the held instruction finishes this cycle or must stall.
  always_comb begin
    stall_s    = 1'b0;
    complete_s = 1'b0;
    case (state_s)
      IDLE: begin
        stall_s    = 1'b0;
        complete_s = 1'b0;
      end
      EXEC: begin
        stall_s    = 1'b0;
        complete_s = 1'b1;
      end
      MEM: begin
        stall_s    = ~dm_ack;
        complete_s = dm_ack;
      end
      default: begin
        stall_s    = 1'b0;
        complete_s = 1'b0;
      end
    endcase
  end

  // Request fields come straight from the EX/MEM register, so they stay
  // stable for the whole access; load+store together is issued as a write.
  assign stall_M  = stall_s;
  assign dm_req   = (state_s == MEM);
  assign dm_we    = exmem_r.mem_write;
  assign dm_addr  = exmem_r.alu_result;
  assign dm_wdata = exmem_r.write_data;

  // Output register: load on completion, otherwise drop the pulse flags and
  // keep the data fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_M     <= 1'b0;
      aluResult_M <= '0;
      readData_M  <= '0;
      PCBranch_M  <= '0;
      PCSrc_M     <= 1'b0;
    end else if (complete_s) begin
      valid_M     <= 1'b1;
      aluResult_M <= exmem_r.alu_result;
      PCBranch_M  <= exmem_r.pc_branch;
      PCSrc_M     <= exmem_r.branch & exmem_r.zero;
      readData_M  <= (exmem_r.mem_read & ~exmem_r.mem_write) ? dm_rdata : '0;
    end else begin
      valid_M     <= 1'b0;
      PCSrc_M     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage with a reactive
// variable-latency memory and an in-order reference model.
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_E, MemRead_E, MemWrite_E, Branch_E, zero_E;
  logic [N-1:0] aluResult_E, writeData_E, PCBranch_E;
  logic         stall_M, dm_req, dm_we, dm_ack;
  logic [N-1:0] dm_addr, dm_wdata, dm_rdata;
  logic         valid_M, PCSrc_M;
  logic [N-1:0] aluResult_M, readData_M, PCBranch_M;

  mem_access_stage dut (
    .clk(clk), .reset(reset), .valid_E(valid_E), .MemRead_E(MemRead_E),
    .MemWrite_E(MemWrite_E), .Branch_E(Branch_E), .zero_E(zero_E),
    .aluResult_E(aluResult_E), .writeData_E(writeData_E), .PCBranch_E(PCBranch_E),
    .stall_M(stall_M), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .valid_M(valid_M), .aluResult_M(aluResult_M), .readData_M(readData_M),
    .PCBranch_M(PCBranch_M), .PCSrc_M(PCSrc_M)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] alu;
    logic [N-1:0] rd;
    logic [N-1:0] pcb;
    logic         pcsrc;
    logic         is_mem;
    int           due;
  } exp_t;

  typedef struct {
    logic         we;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
  } req_t;

  exp_t out_q[$];
  req_t req_q[$];
  int   ack_q[$];
  logic [N-1:0] ref_mem [logic [N-1:0]];
  logic [N-1:0] dev_mem [logic [N-1:0]];

  int   tests = 0;
  int   fails = 0;
  logic mem_hold = 1'b0;
  logic force_ack = 1'b0;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Contents of never-written memory locations.
  function automatic logic [N-1:0] init_val(input logic [N-1:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  // Reference model: instructions complete in order, so loads see every
  // earlier store; non-memory results appear two edges after capture.
  task automatic capture_model();
    exp_t e;
    req_t r;
    e.alu    = aluResult_E;
    e.pcb    = PCBranch_E;
    e.pcsrc  = Branch_E & zero_E;
    e.is_mem = MemRead_E | MemWrite_E;
    e.rd     = '0;
    e.due    = cyc + 2;
    r.addr   = aluResult_E;
    r.wdata  = writeData_E;
    r.we     = MemWrite_E;
    if (MemWrite_E) begin
      ref_mem[aluResult_E] = writeData_E;
      req_q.push_back(r);
    end else if (MemRead_E) begin
      e.rd = ref_mem.exists(aluResult_E) ? ref_mem[aluResult_E] : init_val(aluResult_E);
      req_q.push_back(r);
    end
    out_q.push_back(e);
  endtask

  // Memory device: random 0..3 wait states, random acks while idle.
  always @(posedge clk) begin : memory
    static int  waits = 0;
    static bit  busy  = 1'b0;
    #1;
    if (mem_hold) begin
      dm_ack = force_ack;
      busy   = 1'b0;
    end else if (dm_req) begin
      if (!busy) begin
        busy  = 1'b1;
        waits = $urandom_range(0, 3);
      end
      if (req_q.size() == 0) begin
        chk("unexpected_req", {63'd0, dm_req}, {N{1'b0}});
      end else begin
        chk("dm_we", {63'd0, dm_we}, {63'd0, req_q[0].we});
        chk("dm_addr", dm_addr, req_q[0].addr);
        chk("dm_wdata", dm_wdata, req_q[0].wdata);
      end
      if (waits == 0) begin
        dm_ack = 1'b1;
        if (dm_we) begin
          dev_mem[dm_addr] = dm_wdata;
          dm_rdata = {$urandom(), $urandom()};
        end else begin
          dm_rdata = dev_mem.exists(dm_addr) ? dev_mem[dm_addr] : init_val(dm_addr);
        end
        busy = 1'b0;
        if (req_q.size() != 0) void'(req_q.pop_front());
        ack_q.push_back(cyc + 1);
      end else begin
        dm_ack   = 1'b0;
        dm_rdata = {$urandom(), $urandom()};
        waits--;
      end
    end else begin
      busy     = 1'b0;
      dm_ack   = ($urandom_range(0, 3) == 0);
      dm_rdata = {$urandom(), $urandom()};
    end
  end

  // Stall must exactly cover the request cycles that are not acknowledged.
  always @(negedge clk) begin : stall_mon
    chk("stall_M", {63'd0, stall_M}, {63'd0, dm_req & ~dm_ack});
  end

  // Output scoreboard: every valid_M pulse pops the oldest expected result.
  always @(negedge clk) begin : out_mon
    exp_t e;
    int   due;
    if (valid_M) begin
      if (out_q.size() == 0) begin
        chk("unexpected_valid_M", {63'd0, valid_M}, {N{1'b0}});
      end else begin
        e   = out_q.pop_front();
        due = e.due;
        if (e.is_mem) begin
          if (ack_q.size() == 0) begin
            due = -1;
          end else begin
            due = ack_q.pop_front();
          end
        end
        chk("latency", 64'(cyc), 64'(due));
        chk("aluResult_M", aluResult_M, e.alu);
        chk("readData_M", readData_M, e.rd);
        chk("PCBranch_M", PCBranch_M, e.pcb);
        chk("PCSrc_M", {63'd0, PCSrc_M}, {63'd0, e.pcsrc});
      end
    end else begin
      chk("PCSrc_M_idle", {63'd0, PCSrc_M}, {N{1'b0}});
    end
  end

  task automatic rand_instr();
    int kind;
    kind        = $urandom_range(0, 7);
    valid_E     = ($urandom_range(0, 9) != 0);
    MemRead_E   = (kind == 2 || kind == 3 || kind == 6);
    MemWrite_E  = (kind == 4 || kind == 6 || kind == 7);
    Branch_E    = (kind == 5);
    zero_E      = $urandom_range(0, 1) != 0;
    writeData_E = {$urandom(), $urandom()};
    PCBranch_E  = {$urandom(), $urandom()};
    if (MemRead_E || MemWrite_E) aluResult_E = 64'($urandom_range(0, 7)) << 3;
    else aluResult_E = {$urandom(), $urandom()};
  endtask

  // Hold the presented instruction until the stage accepts it.
  task automatic wait_capture();
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      if (!stall_M) begin
        if (valid_E) capture_model();
        return;
      end
    end
    chk("capture_timeout", {63'd0, stall_M}, {N{1'b0}});
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    reset = 1'b1; valid_E = 1'b0; MemRead_E = 1'b0; MemWrite_E = 1'b0;
    Branch_E = 1'b0; zero_E = 1'b0; aluResult_E = '0; writeData_E = '0; PCBranch_E = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dm_req", {63'd0, dm_req}, {N{1'b0}});
    chk("rst_stall_M", {63'd0, stall_M}, {N{1'b0}});
    chk("rst_valid_M", {63'd0, valid_M}, {N{1'b0}});
    chk("rst_aluResult_M", aluResult_M, {N{1'b0}});
    chk("rst_readData_M", readData_M, {N{1'b0}});
    chk("rst_PCBranch_M", PCBranch_M, {N{1'b0}});
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 600; i++) begin
      rand_instr();
      wait_capture();
      @(posedge clk); #1;
    end
    valid_E = 1'b0;
    for (int n = 0; n < 50 && out_q.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    chk("drain_out_q", 64'(out_q.size()), {N{1'b0}});
    chk("drain_req_q", 64'(req_q.size()), {N{1'b0}});

    // Reset in the middle of a stalled load abandons it; a late ack is ignored.
    @(posedge clk); #1;
    mem_hold = 1'b1; force_ack = 1'b0;
    @(posedge clk); #1;
    valid_E = 1'b1; MemRead_E = 1'b1; MemWrite_E = 1'b0; Branch_E = 1'b0;
    aluResult_E = 64'h100;
    @(posedge clk); #1;
    valid_E = 1'b0; MemRead_E = 1'b0;
    @(negedge clk);
    chk("abort_dm_req_before", {63'd0, dm_req}, {63'd0, 1'b1});
    chk("abort_dm_addr", dm_addr, 64'h100);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_dm_req_after", {63'd0, dm_req}, {N{1'b0}});
    chk("abort_stall_M", {63'd0, stall_M}, {N{1'b0}});
    chk("abort_valid_M", {63'd0, valid_M}, {N{1'b0}});
    force_ack = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("late_ack_valid_M", {63'd0, valid_M}, {N{1'b0}});
      chk("late_ack_dm_req", {63'd0, dm_req}, {N{1'b0}});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
